poly1305_block_packer: RTL and testbench
========================================

Name: poly1305_block_packer

Overview:
- Upstream feeder for the ChaCha20-Poly1305 MAC datapath.
- Accepts AAD and ciphertext as a 32-bit word stream and assembles 16-byte little-endian blocks.
- Zero-pads the tail of each segment to 16 bytes, then appends the final length block (aad_len || ct_len).
- Presents each 128-bit block to the MAC core over a valid/ready handshake.

Parameters:
- LEN_W, 64, width of the internal byte-length counters (1..64). Zero-extended to 64 bits in the length block; counters wrap modulo 2^LEN_W.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a message; accepted only in IDLE
- busy  output  1  high in every state except IDLE
- in_valid  input  1  input word valid
- in_ready  output  1  input word accepted when in_valid && in_ready
- in_data  input  32  byte j of the word = in_data[8j+7:8j]; byte 0 is first in stream
- in_bytes  input  3  valid bytes in the word, low lanes first; 0..4
- in_last  input  1  last word of the current segment (AAD, then CT)
- blk_valid  output  1  output block valid
- blk_ready  input  1  downstream accepts the block
- blk_data  output  128  byte k = blk_data[8k+7:8k]
- blk_last  output  1  high with the length block only
- done  output  1  one-cycle pulse when the length block is accepted

Behaviour:
- Reset values: in_ready=0, blk_valid=0, blk_data=0, blk_last=0, done=0, busy=0. Assembly buffer, byte count and length counters are cleared; state=IDLE.
- Reset mid-operation aborts the message immediately; no partial block is emitted.
- States: IDLE -> AAD on start. AAD -> CT on an accepted word with in_last. CT -> LEN on an accepted word with in_last. LEN -> IDLE when the length block is accepted.
- start while busy is ignored.
- in_ready = (state==AAD or CT) && (!blk_valid || blk_ready). Evaluated combinationally.
- Assembly: an accepted word writes in_bytes bytes at buffer offset cnt; cnt += in_bytes. The segment length counter (aad_len or ct_len) += in_bytes.
- in_bytes must be 4 unless in_last=1, so cnt is always a multiple of 4 and a word never straddles two blocks.
- Block emit: when cnt reaches 16, or when in_last is accepted with cnt_after>0:
  - the buffer, zero-padded above cnt, loads the output register in the next cycle (blk_valid=1);
  - the buffer and cnt clear.
- Empty segment: in_bytes=0 with in_last=1 and cnt==0 emits no block; it only advances the state.
- Latency: a block-completing word accepted at cycle t gives blk_valid=1 at t+1.
- The output register holds blk_data stable until blk_valid && blk_ready.
- Back-to-back operation: an input accept and an output accept may occur in the same cycle. Full throughput is 4 words per block with no bubble.
- LEN state:
  - entered after the CT in_last word; its padded block (if any) is emitted first;
  - the length block then loads as soon as the output register is free;
  - blk_data[63:0]=aad_len, blk_data[127:64]=ct_len, both byte counts, little-endian; blk_last=1.
- done pulses in the cycle after the length block handshake. busy falls in that same cycle.
- Length counter overflow wraps silently. No error is reported in the base build.

Optional Feature:
- Macro POLY1305_PACK_PROTO_CHECK_EN adds output proto_err (1 bit, sticky, cleared by reset or accepted start).
- proto_err sets on any of:
  - an accepted word with in_bytes>4;
  - an accepted word with in_bytes!=4 && !in_last;
  - in_valid asserted in IDLE or LEN.
- The offending word is still consumed with its bytes clipped to 4.
- Without the macro the port is absent and behaviour on such input is undefined.

Test Plan:
- RFC 8439 sizes: start, AAD 12 bytes (3 words, last has in_bytes=4), CT 114 bytes (28 full words + 1 word in_bytes=2) -> exactly 10 blocks:
  - block 0 bytes 12..15 zero;
  - block 8 bytes 2..15 zero;
  - block 9: blk_data[63:0]=0x0C, blk_data[127:64]=0x72, blk_last=1;
  - done one cycle after the block 9 handshake.
- Empty AAD and empty CT (both in_bytes=0 with in_last) -> exactly one block, all zero, blk_last=1; done follows.
- Backpressure: hold blk_ready=0 for 5 cycles while a full block is pending -> blk_data stable, in_ready=0 after the next block completes, no data lost; release -> blocks resume in order.
- Throughput: blk_ready=1 constantly, 64-byte CT -> one block every 4 cycles, in_ready never deasserts.
- Reset asserted while in CT with cnt=8 -> all outputs return to reset values asynchronously; a new start then produces correct lengths from zero.
- With POLY1305_PACK_PROTO_CHECK_EN: a word with in_bytes=3, in_last=0 -> proto_err=1 from the next cycle until the next accepted start.

Source files
------------

// File: rtl/poly1305_block_packer.sv
// poly1305_block_packer: packs a 32-bit AAD/CT word stream into zero-padded
// 16-byte little-endian blocks, then appends the (aad_len || ct_len) block.
// Optional build macro POLY1305_PACK_PROTO_CHECK_EN adds a sticky proto_err output.
module poly1305_block_packer #(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_bytes,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [127:0] blk_data,
  output logic         blk_last,
  output logic         done
`ifdef POLY1305_PACK_PROTO_CHECK_EN
  ,
  output logic         proto_err
`endif
);

  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {IDLE, AAD, CT, LEN} state_t;

  state_t             state_q, state_d;
  logic [15:0][7:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_after;
  logic [LEN_W-1:0]   aad_len_q, ct_len_q;
  logic               len_sent_q;
  logic               out_free, acc, emit, len_load, blk_hs, last_hs;
  logic [2:0]         nb;

  // Handshake and emit decisions for this cycle
  always_comb begin
    out_free  = !blk_valid || blk_ready;
    in_ready  = ((state_q == AAD) || (state_q == CT)) && out_free;
    acc       = in_valid && in_ready;
    nb        = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    cnt_after = cnt_q + CNT_W'(nb);
    emit      = acc && ((cnt_after == CNT_W'(16)) || (in_last && (cnt_after != '0)));
    len_load  = (state_q == LEN) && !len_sent_q && out_free;
    blk_hs    = blk_valid && blk_ready;
    last_hs   = blk_hs && blk_last;
    busy      = (state_q != IDLE);
  end

  // Buffer with the incoming word merged at byte offset cnt
  always_comb begin
    buf_d = buf_q;
    for (int j = 0; j < 4; j++) begin
      if (3'(j) < nb) buf_d[{cnt_q[3:2], 2'(j)}] = in_data[8*j +: 8];
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = AAD;
      AAD:     if (acc && in_last) state_d = CT;
      CT:      if (acc && in_last) state_d = LEN;
      LEN:     if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Assembly buffer, length counters and output block register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q      <= '0;
      cnt_q      <= '0;
      aad_len_q  <= '0;
      ct_len_q   <= '0;
      len_sent_q <= 1'b0;
      blk_valid  <= 1'b0;
      blk_data   <= '0;
      blk_last   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= last_hs;
      if ((state_q == IDLE) && start) begin
        buf_q      <= '0;
        cnt_q      <= '0;
        aad_len_q  <= '0;
        ct_len_q   <= '0;
        len_sent_q <= 1'b0;
      end
      if (acc) begin
        if (emit) begin
          buf_q <= '0;
          cnt_q <= '0;
        end else begin
          buf_q <= buf_d;
          cnt_q <= cnt_after;
        end
        if (state_q == AAD) aad_len_q <= aad_len_q + LEN_W'(nb);
        else                ct_len_q  <= ct_len_q + LEN_W'(nb);
      end
      if (emit) begin
        blk_data  <= buf_d;
        blk_valid <= 1'b1;
        blk_last  <= 1'b0;
      end else if (len_load) begin
        blk_data   <= {64'(ct_len_q), 64'(aad_len_q)};
        blk_valid  <= 1'b1;
        blk_last   <= 1'b1;
        len_sent_q <= 1'b1;
      end else if (blk_hs) begin
        blk_valid <= 1'b0;
        blk_last  <= 1'b0;
      end
    end
  end

`ifdef POLY1305_PACK_PROTO_CHECK_EN
  logic perr_set;

  // Protocol violations seen on the input side this cycle
  always_comb begin
    perr_set = (acc && ((in_bytes > 3'd4) || ((in_bytes != 3'd4) && !in_last))) ||
               (in_valid && ((state_q == IDLE) || (state_q == LEN)));
  end

  // Sticky error flag, cleared by an accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            proto_err <= 1'b0;
    else if (perr_set)                    proto_err <= 1'b1;
    else if ((state_q == IDLE) && start)  proto_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_poly1305_block_packer.sv
// Scoreboard bench for poly1305_block_packer: expected blocks are derived from
// the byte streams by chunk-and-pad, then checked by a monitor on each handshake.
module tb_poly1305_block_packer;

  typedef byte unsigned bq_t[$];
  typedef struct packed {
    logic         last;
    logic [127:0] data;
  } blk_t;

  logic         clk = 1'b0;
  logic         reset, start, in_valid, in_last, blk_ready;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic         busy, in_ready, blk_valid, blk_last, done;
  logic [127:0] blk_data;
`ifdef POLY1305_PACK_PROTO_CHECK_EN
  logic         proto_err;
`endif

  poly1305_block_packer #(.LEN_W(64)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_bytes(in_bytes), .in_last(in_last),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_last(blk_last), .done(done)
`ifdef POLY1305_PACK_PROTO_CHECK_EN
    , .proto_err(proto_err)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   nblk   = 0;
  int   stalls = 0;
  blk_t exp_q[$];
  blk_t mon_e;
  bit   hold_ready = 0;
  bit   rand_ready = 0;
  bit   done_expect = 0;
  bit   msg_done = 0;

  // Downstream ready pattern
  initial begin
    blk_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      blk_ready = hold_ready ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: compares every block handshake and the done pulse
  always @(negedge clk) begin
    if (done_expect) begin
      checks++;
      if (!(done === 1'b1 && busy === 1'b0)) begin
        errors++;
        $display("FAIL done_pulse: done=%b busy=%b required done=1 busy=0", done, busy);
      end
      done_expect = 0;
      msg_done = 1;
    end else if (done === 1'b1) begin
      checks++; errors++;
      $display("FAIL unexpected_done: done=1 required 0");
    end
    if (!reset && blk_valid && blk_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_block: got %h last=%b, none expected", blk_data, blk_last);
      end else begin
        mon_e = exp_q.pop_front();
        nblk++;
        if (blk_data !== mon_e.data || blk_last !== mon_e.last) begin
          errors++;
          $display("FAIL block_%0d: got %h last=%b required %h last=%b",
                   nblk, blk_data, blk_last, mon_e.data, mon_e.last);
        end
        if (blk_last === 1'b1) done_expect = 1;
      end
    end
  end

  // Expected blocks for one segment: 16-byte chunks, zero padded
  task automatic push_seg(input bq_t s);
    int n = s.size();
    for (int b = 0; b * 16 < n; b++) begin
      blk_t e;
      e.last = 1'b0;
      e.data = '0;
      for (int k = 0; k < 16; k++)
        if (b * 16 + k < n) e.data[8*k +: 8] = s[b*16+k];
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input bit last, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = d; in_bytes = nb; in_last = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++; t++;
      if (t > 500) begin
        checks++; errors++;
        $display("FAIL in_accept_timeout: in_ready=0 for %0d cycles required 1", t);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_seg(input bq_t s, input bit gaps);
    int n = s.size();
    int nb;
    logic [31:0] d;
    if (n == 0) send_word($urandom(), 3'd0, 1'b1, gaps);
    else for (int w = 0; w * 4 < n; w++) begin
      nb = (n - 4 * w >= 4) ? 4 : n - 4 * w;
      d = $urandom();
      for (int j = 0; j < 4; j++)
        if (j < nb) d[8*j +: 8] = s[4*w+j];
      send_word(d, 3'(nb), (4 * w + 4 >= n), gaps);
    end
  endtask

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom()));
    return q;
  endfunction

  // One full message: expectations pushed up front, then stimulus, then bounded wait
  task automatic run_msg(input int aad_n, input int ct_n, input bit gaps, input bit extra_start);
    bq_t a, c;
    blk_t lb;
    int nb0, t, exp_cnt;
    a = rand_bytes(aad_n);
    c = rand_bytes(ct_n);
    push_seg(a);
    push_seg(c);
    lb.last = 1'b1;
    lb.data = {64'(ct_n), 64'(aad_n)};
    exp_q.push_back(lb);
    exp_cnt = (aad_n + 15) / 16 + (ct_n + 15) / 16 + 1;
    nb0 = nblk;
    msg_done = 0;
    pulse_start();
    send_seg(a, gaps);
    if (extra_start) pulse_start();
    send_seg(c, gaps);
    t = 0;
    while (!msg_done && t < 3000) begin @(posedge clk); t++; end
    #1;
    checks++;
    if (!msg_done) begin
      errors++;
      $display("FAIL msg_timeout: aad=%0d ct=%0d no done after %0d cycles", aad_n, ct_n, t);
    end else if (nblk - nb0 != exp_cnt || exp_q.size() != 0) begin
      errors++;
      $display("FAIL block_count: aad=%0d ct=%0d got %0d blocks required %0d (left %0d)",
               aad_n, ct_n, nblk - nb0, exp_cnt, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({in_ready, blk_valid, blk_last, done, busy} !== 5'b0 || blk_data !== 128'd0) begin
      errors++;
      $display("FAIL %s: in_ready=%b blk_valid=%b blk_last=%b done=%b busy=%b blk_data=%h required all 0",
               name, in_ready, blk_valid, blk_last, done, busy, blk_data);
    end
  endtask

  initial begin
    bq_t a;
    int t;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_bytes = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    reset = 1'b0;
    @(posedge clk); #1;

    // RFC 8439 sizes: 12-byte AAD, 114-byte CT -> 10 blocks
    run_msg(12, 114, 0, 0);
    // Both segments empty -> single zero length block
    run_msg(0, 0, 0, 0);

    // Throughput: 64-byte CT with constant ready, no input stalls
    stalls = 0;
    run_msg(0, 64, 0, 0);
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL throughput_stalls: got %0d required 0", stalls);
    end

    // Backpressure: hold ready low while a block is pending
    hold_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    fork
      run_msg(32, 20, 0, 0);
      begin
        t = 0;
        do begin @(negedge clk); t++; end while (!blk_valid && t < 200);
        for (int i = 0; i < 5; i++) begin
          checks++;
          if (!blk_valid || exp_q.size() == 0 || blk_data !== exp_q[0].data) begin
            errors++;
            $display("FAIL bp_hold_%0d: blk_valid=%b blk_data=%h required pending block", i, blk_valid, blk_data);
          end
          @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready: got %b required 0", in_ready);
        end
        hold_ready = 0;
      end
    join

    // Randomized messages with random ready and input gaps
    rand_ready = 1;
    run_msg(5, 33, 1, 1);
    for (int m = 0; m < 8; m++) run_msg($urandom_range(0, 70), $urandom_range(0, 70), 1, m == 3);
    rand_ready = 0;
    @(posedge clk); #1;

    // Reset in CT with cnt=8, then a clean message
    exp_q.delete();
    a = rand_bytes(8);
    push_seg(a);
    pulse_start();
    send_seg(a, 0);
    send_word($urandom(), 3'd4, 1'b0, 0);
    send_word($urandom(), 3'd4, 1'b0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset_mid_ct");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pre_reset_blocks: %0d expected blocks not seen required 0", exp_q.size());
    end
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_msg(20, 9, 0, 0);

`ifdef POLY1305_PACK_PROTO_CHECK_EN
    // Short non-last word flags a sticky protocol error
    pulse_start();
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_err_clear: got %b required 0", proto_err);
    end
    send_word($urandom(), 3'd3, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (proto_err !== 1'b1) begin
        errors++;
        $display("FAIL proto_err_set_%0d: got %b required 1", i, proto_err);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_err_reset: got %b required 0", proto_err);
    end
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
